// File: rtl/fir_mac_sequencer.sv
// FIR front end: sample history, coefficient bank and MAC sequencing into the
// external filter_accumulator, followed by round/saturate of its 40-bit sum.
module fir_mac_sequencer #(
    parameter int TAPS = 16,
    parameter int DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [DW-1:0]           coef_wdata,
    output logic                    acc_enable,
    output logic                    acc_load,
    output logic [31:0]             acc_d,
    input  logic signed [39:0]      acc_q,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    busy
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] ONE_A  = AW'(1);
    localparam logic [AW-1:0] ZERO_A = AW'(0);
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [AW-1:0]        wr_ptr_r, wr_ptr_s;
    logic [AW-1:0]        k_r, k_s;
    logic signed [DW-1:0] hist_r [TAPS];
    logic signed [DW-1:0] coef_r [TAPS];
    logic                 hist_we_s, coef_we_s;
    logic                 acc_enable_s, acc_load_s, out_valid_s;
    logic [31:0]          acc_d_s;
    logic [DW-1:0]        out_data_s;
    logic [AW-1:0]        idx_s;
    logic signed [31:0]   coef_ext_s, hist_ext_s, prod_s;
    logic signed [40:0]   rnd_s, sh_s;

    // Clamp the rounded Q1.15 result into the 16-bit signed range.
    function automatic logic [15:0] sat16(input logic signed [40:0] v);
        logic [15:0] r;
        if (v > 41'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -41'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Newest sample sits one slot behind the write pointer; tap k looks k further back.
    assign idx_s      = wr_ptr_r - ONE_A - k_r;
    assign coef_ext_s = 32'(coef_r[k_r]);
    assign hist_ext_s = 32'(hist_r[idx_s]);
    assign prod_s     = coef_ext_s * hist_ext_s;
    assign rnd_s      = $signed({acc_q[39], acc_q}) + 41'sd16384;
    assign sh_s       = rnd_s >>> 5'd15;

    assign in_ready = (state_r == S_IDLE);
    assign busy     = (state_r != S_IDLE);

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_s      = state_r;
        wr_ptr_s     = wr_ptr_r;
        k_s          = k_r;
        hist_we_s    = 1'b0;
        coef_we_s    = 1'b0;
        acc_enable_s = 1'b0;
        acc_load_s   = 1'b0;
        acc_d_s      = acc_d;
        out_valid_s  = 1'b0;
        out_data_s   = out_data;
        case (state_r)
            S_IDLE: begin
                coef_we_s = coef_we;
                if (in_valid) begin
                    hist_we_s = 1'b1;
                    wr_ptr_s  = wr_ptr_r + ONE_A;
                    k_s       = ZERO_A;
                    state_s   = S_MAC;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_MAC: begin
                acc_d_s      = prod_s;
                acc_enable_s = 1'b1;
                acc_load_s   = (k_r == ZERO_A);
                if (k_r == K_LAST) begin
                    state_s = S_WAIT;
                end else begin
                    k_s = k_r + ONE_A;
                end
            end
            S_WAIT: begin
                state_s = S_OUT;
            end
            S_OUT: begin
                out_data_s  = sat16(sh_s);
                out_valid_s = 1'b1;
                state_s     = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, write pointer and tap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            wr_ptr_r <= ZERO_A;
            k_r      <= ZERO_A;
        end else begin
            state_r  <= state_s;
            wr_ptr_r <= wr_ptr_s;
            k_r      <= k_s;
        end
    end

    // Registered outputs toward the accumulator and the output consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_enable <= 1'b0;
            acc_load   <= 1'b0;
            acc_d      <= 32'd0;
            out_valid  <= 1'b0;
            out_data   <= {DW{1'b0}};
        end else begin
            acc_enable <= acc_enable_s;
            acc_load   <= acc_load_s;
            acc_d      <= acc_d_s;
            out_valid  <= out_valid_s;
            out_data   <= out_data_s;
        end
    end

    // Sample history and coefficient bank storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_r[i] <= {DW{1'b0}};
                coef_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (hist_we_s) begin
                hist_r[wr_ptr_r] <= in_data;
            end
            if (coef_we_s) begin
                coef_r[coef_addr] <= coef_wdata;
            end
        end
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequencer and datapath front end for the FIR filter. It buffers input samples and holds the coefficient bank. For each accepted sample it streams TAPS signed coefficient×sample products into the downstream `filter_accumulator`, driving that block's `enable`, `load` and `D` inputs. It then reads back the 40-bit accumulated sum, rounds and saturates it, and emits one 16-bit filtered output per input sample.

## Interface
- TAPS, 16, number of filter taps (power of two, 4..64)
- DW, 16, sample and coefficient width (signed Q1.15)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample (state==IDLE, combinational from state register)
- in_data  in  DW  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS)  coefficient index k
- coef_wdata  in  DW  signed coefficient value
- acc_enable  out  1  to accumulator `enable`, registered
- acc_load  out  1  to accumulator `load`, registered
- acc_d  out  32  signed product to accumulator `D`, registered
- acc_q  in  40  signed accumulator `Q`
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  DW  signed filtered output
- busy  out  1  state != IDLE

## Operation
- Storage: TAPS-entry sample history, circular, with write pointer wr_ptr. Also a TAPS-entry coefficient bank. Reset clears both to 0.
- States: IDLE → MAC → WAIT → OUT → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: write in_data at wr_ptr, advance wr_ptr (wraps TAPS-1→0), set tap counter k=0, go to MAC.
- MAC, one cycle per k = 0..TAPS-1:
  - Register acc_d = coef[k] × x[n-k], where x[n] is the newest sample. History index is (newest_ptr − k) mod TAPS.
  - Same edge: acc_enable=1, and acc_load=1 only for k==0.
  - After k==TAPS-1, go to WAIT.
- WAIT: register acc_enable=0, acc_load=0. acc_d holds its last value. Go to OUT.
- OUT:
  - acc_q now holds the full sum.
  - Register out_data = sat16((acc_q + 2^14) >>> 15), i.e. round half up, arithmetic shift.
  - Saturate to [-32768, 32767]. out_valid=1 for one cycle. Go to IDLE.
- Arithmetic:
  - Product is 16×16 signed to 32-bit Q2.30. -32768×-32768 = 2^30 fits without overflow.
  - Sum is 40-bit, handled by the accumulator. TAPS ≤ 64 cannot overflow it.
- Coefficient writes are accepted only in IDLE. coef_we outside IDLE is ignored and leaves the bank unchanged.
- Simultaneous coef_we and in_valid in IDLE: both take effect. The new coefficient is used for that same sample.
- No output backpressure: out_valid is a pulse. The consumer must capture it.
- Reset mid-operation:
  - State goes to IDLE and history/coefs are cleared.
  - acc_enable, acc_load, out_valid go to 0. acc_d and out_data go to 0.
  - The accumulator shares rst_n and clears with it.

## Timing
- Reset values: in_ready=1, busy=0, acc_enable=0, acc_load=0, acc_d=0, out_valid=0, out_data=0.
- Let E0 be the accepting edge (in_valid & in_ready).
- Edges E0+1..E0+TAPS: acc_d carries p0..p(TAPS-1), with acc_enable=1. acc_load=1 only after E0+1.
- Accumulator captures at E0+2..E0+TAPS+1.
- Edge E0+TAPS+1: acc_enable falls.
- Edge E0+TAPS+2: out_valid rises for one cycle and state returns to IDLE.
- Accept-to-output latency: TAPS+2 cycles. Next acceptance is possible no earlier than edge E0+TAPS+3. Throughput is one sample per TAPS+3 cycles (19 for TAPS=16).
- acc_enable is high for exactly TAPS consecutive cycles per sample. acc_load is high exactly once per sample, and only while acc_enable=1.

## Test plan
1. Impulse, uniform coefficients:
   - Stimulus: all coef=0x4000; input 0x4000 once, then 0x0000.
   - Required: first 16 outputs are 0x2000, then 0x0000.
2. Impulse, tap ordering:
   - Stimulus: coef[k]=k×0x0100; input 0x7FFF, then zeros.
   - Required: output n = n×0x0100 for n=0..15, then 0.
3. Saturation:
   - Stimulus: all coef=0x7FFF; sustained input 0x7FFF. Then sustained input 0x8000.
   - Required: positive input reaches 0x7FFF by the 2nd output and holds. Negative input settles at 0x8000. No wrap.
4. Handshake timing:
   - Stimulus: in_valid held high continuously.
   - Required: acceptances exactly 19 cycles apart. out_valid exactly 18 edges after each accept. One acc_load per sample. 16 acc_enable cycles per sample.
5. Coefficient gating:
   - Stimulus: coef_we during MAC with a new value. Coef_we in the same IDLE cycle as in_valid.
   - Required: the first write is ignored (bank unchanged). The second takes effect for that sample's output.
6. Reset mid-operation:
   - Stimulus: assert rst_n low at k=7 of MAC.
   - Required: acc_enable=0, out_valid=0, in_ready=1 immediately. After a re-program and impulse, the response matches a fresh run.
